pc_ras: RTL and testbench
=========================

# pc_ras

Parametrised program counter with branch, call/return and a hardware return-address stack (RAS). It drives the instruction-memory address each cycle, taking redirect requests from the control unit and stall requests from hazard logic. All state updates on the rising edge of `clk`; no negedge logic.

## Interface
- `AW`, 8, address/PC width in bits
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2)
- `RESET_VEC`, 0, PC value loaded at reset
- `clk  input  1  clock, all state rising-edge`
- `rst_n  input  1  synchronous, active-low reset`
- `stall  input  1  hold PC and RAS; all other requests ignored`
- `br_en  input  1  branch/jump taken`
- `br_rel  input  1  1: target = pc + br_target (two's complement); 0: target = br_target`
- `br_target  input  AW  absolute address or signed offset`
- `call  input  1  push return address pc+1, jump to target`
- `ret  input  1  pop return address into PC`
- `pc  output  AW  current PC, registered, to instruction memory`
- `ras_empty  output  1  stack holds 0 entries`
- `ras_full  output  1  stack holds RAS_DEPTH entries`
- `ras_ovf  output  1  sticky: call made while full`
- `ras_unf  output  1  sticky: ret made while empty`

## Operation
- Priority per cycle: reset > stall > {call&ret} > ret > call > br_en > increment.
- Reset (rst_n=0 at posedge): pc=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
- stall=1: pc, RAS contents, count and flags unchanged.
- Target: br_rel ? pc + br_target : br_target, modulo 2^AW. Used by br_en, call and call&ret.
- Increment: pc <= pc+1, wraps from all-ones to 0.
- br_en only: pc <= target.
- call (br_en ignored): push pc+1 (mod 2^AW); pc <= target. If full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_ovf set.
- ret: if non-empty, pc <= top, count−1. If empty: pc <= pc+1, ras_unf set, count stays 0.
- call&ret together (exchange): pc <= target; top entry replaced with pc+1; count unchanged. If empty: behaves as plain call and ras_unf set.
- Sticky flags clear only on reset.

## Timing
- All outputs registered; request sampled at posedge N appears on pc after posedge N (one-cycle redirect latency, no bubble logic inside the block).
- ras_empty/ras_full reflect count after the same edge that updates pc.
- Relative target uses pc value before the edge.
- Return address pushed is pc+1 of the calling instruction, not the target.
- Reset mid-sequence (e.g. during back-to-back calls) discards all RAS state in one cycle; stall is ignored during reset.

## Structure
- Shared package `pc_pkg`: enum `pc_op_t` {PC_INC, PC_HOLD, PC_BR, PC_CALL, PC_RET, PC_XCHG}, function for priority decode, default parameter constants.
- Sub-module `ras_lifo`: circular LIFO (push/pop/replace, top-of-stack output, count, full/empty, overwrite-oldest on full push); parametrised by AW and RAS_DEPTH.
- Top: op decode, target adder, PC register, flag registers.

## Test plan
AW=8, RAS_DEPTH=4, RESET_VEC=0.
- Reset, then 300 idle cycles -> pc 0,1,…,255,0,1,… (wrap after 255); flags all 0, ras_empty=1.
- At pc=0x10: br_en=1, br_rel=1, br_target=0xF0 (−16) -> pc=0x00 next cycle; br_rel=0, br_target=0x80 -> pc=0x80.
- At pc=0x20: call, target 0x40 -> pc=0x40, ras_empty=0; then ret -> pc=0x21, ras_empty=1.
- Five nested calls from pc 0x01,0x11,0x21,0x31,0x41 (each target +0x0F) -> ras_full=1, ras_ovf=1 after 5th; four rets return 0x42,0x32,0x22,0x12; fifth ret -> pc = previous pc+1, ras_unf=1.
- stall=1 held 3 cycles with call asserted -> pc and count unchanged; release with call -> push occurs once.
- call&ret together at pc=0x50, stack top 0x30, target 0x60 -> pc=0x60, top=0x51, count unchanged; then rst_n=0 mid-stream -> pc=0, count=0, flags cleared.

Source files
------------

// File: rtl/pc_ras_pkg.sv
// Shared types and helpers for the program counter with return-address stack:
// operation encoding, per-cycle priority decode and default parameter values.
package pc_pkg;

    localparam int PC_AW_DEF     = 8;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int RESET_VEC_DEF = 0;

    typedef enum logic [2:0] {
        PC_INC  = 3'd0,
        PC_HOLD = 3'd1,
        PC_BR   = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4,
        PC_XCHG = 3'd5
    } pc_op_t;

    // Priority: stall > call&ret > ret > call > branch > increment.
    function automatic pc_op_t pc_op_decode(input logic stall, input logic call,
                                            input logic ret, input logic br_en);
        pc_op_t op;
        if (stall) begin
            op = PC_HOLD;
        end else if (call && ret) begin
            op = PC_XCHG;
        end else if (ret) begin
            op = PC_RET;
        end else if (call) begin
            op = PC_CALL;
        end else if (br_en) begin
            op = PC_BR;
        end else begin
            op = PC_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_ras_if.sv
// Request/response bundle between the control unit and the program counter.
interface pc_ras_if import pc_pkg::*; #(
    parameter int AW = PC_AW_DEF
);
    logic          stall;
    logic          br_en;
    logic          br_rel;
    logic [AW-1:0] br_target;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_ovf;
    logic          ras_unf;

    modport master (
        output stall, br_en, br_rel, br_target, call, ret,
        input  pc, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, br_en, br_rel, br_target, call, ret,
        output pc, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras_lifo.sv
// Circular return-address LIFO: push/pop/replace-top; a push while full
// silently overwrites the oldest entry because the write pointer wraps onto it.
module ras_lifo #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          replace,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem_r [DEPTH];
    logic [PW-1:0] sp_r;
    logic [PW-1:0] sp_nxt_s;
    logic [PW:0]   count_r;
    logic [PW:0]   count_nxt_s;
    logic          empty_r;
    logic          full_r;

    assign top   = mem_r[sp_r - PW'(1)];
    assign empty = empty_r;
    assign full  = full_r;

    // Next stack pointer and occupancy; count saturates at DEPTH on overwrite.
    always_comb begin
        sp_nxt_s    = sp_r;
        count_nxt_s = count_r;
        if (push) begin
            sp_nxt_s    = sp_r + PW'(1);
            count_nxt_s = full_r ? count_r : (count_r + (PW+1)'(1));
        end else if (pop) begin
            sp_nxt_s    = sp_r - PW'(1);
            count_nxt_s = count_r - (PW+1)'(1);
        end else begin
            sp_nxt_s    = sp_r;
            count_nxt_s = count_r;
        end
    end

    // Stack storage, pointer, count and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_r    <= '0;
            count_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            sp_r    <= sp_nxt_s;
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == (PW+1)'(0));
            full_r  <= (count_nxt_s == (PW+1)'(DEPTH));
            if (push) begin
                mem_r[sp_r] <= din;
            end else if (replace) begin
                mem_r[sp_r - PW'(1)] <= din;
            end
        end
    end
endmodule

// File: rtl/pc_ras.sv
// Program counter with branch, call/return and hardware return-address stack.
// One-cycle redirect latency; all outputs come straight from registers.
module pc_ras import pc_pkg::*; #(
    parameter int AW        = PC_AW_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int RESET_VEC = RESET_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_ras_if.slave     bus
);
    pc_op_t        op_s;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_nxt_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] target_s;
    logic [AW-1:0] ras_top_s;
    logic          ras_empty_s;
    logic          ras_full_s;
    logic          push_s;
    logic          pop_s;
    logic          replace_s;
    logic          ovf_r;
    logic          unf_r;

    assign op_s     = pc_op_decode(bus.stall, bus.call, bus.ret, bus.br_en);
    assign pc_inc_s = pc_r + AW'(1);

    // Exchange on an empty stack degenerates into a plain push.
    assign push_s    = (op_s == PC_CALL) || ((op_s == PC_XCHG) && ras_empty_s);
    assign pop_s     = (op_s == PC_RET)  && !ras_empty_s;
    assign replace_s = (op_s == PC_XCHG) && !ras_empty_s;

    // Redirect target and next-PC selection.
    always_comb begin
        if (bus.br_rel) begin
            target_s = pc_r + bus.br_target;
        end else begin
            target_s = bus.br_target;
        end
        case (op_s)
            PC_INC:  pc_nxt_s = pc_inc_s;
            PC_HOLD: pc_nxt_s = pc_r;
            PC_BR:   pc_nxt_s = target_s;
            PC_CALL: pc_nxt_s = target_s;
            PC_XCHG: pc_nxt_s = target_s;
            PC_RET:  pc_nxt_s = ras_empty_s ? pc_inc_s : ras_top_s;
            default: pc_nxt_s = pc_r;
        endcase
    end

    // PC register and sticky overflow/underflow flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r  <= RESET_VEC[AW-1:0];
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r <= pc_nxt_s;
            if ((op_s == PC_CALL) && ras_full_s) begin
                ovf_r <= 1'b1;
            end
            if (((op_s == PC_RET) || (op_s == PC_XCHG)) && ras_empty_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    ras_lifo #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_lifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .replace (replace_s),
        .din     (pc_inc_s),
        .top     (ras_top_s),
        .empty   (ras_empty_s),
        .full    (ras_full_s)
    );

    assign bus.pc        = pc_r;
    assign bus.ras_empty = ras_empty_s;
    assign bus.ras_full  = ras_full_s;
    assign bus.ras_ovf   = ovf_r;
    assign bus.ras_unf   = unf_r;
endmodule

// File: tb/tb_pc_ras.sv
// Directed self-checking bench for pc_ras (AW=8, RAS_DEPTH=4, RESET_VEC=0).
module tb_pc_ras;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    pc_ras_if #(.AW(8)) bus ();

    pc_ras #(
        .AW        (8),
        .RAS_DEPTH (4),
        .RESET_VEC (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 1'b0; bus.br_en = 1'b0; bus.br_rel = 1'b0;
        bus.br_target = 8'h00; bus.call = 1'b0; bus.ret = 1'b0;
    endtask

    task automatic chk_pc(input string name, input logic [7:0] exp);
        total_cnt++;
        if (bus.pc !== exp) $display("FAIL %s: pc got %h expected %h", name, bus.pc, exp);
        else pass_cnt++;
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        total_cnt++;
        if ({bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf} !== exp)
            $display("FAIL %s: {empty,full,ovf,unf} got %b expected %b", name,
                     {bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf}, exp);
        else pass_cnt++;
    endtask

    task automatic jump_abs(input logic [7:0] t);
        idle(); bus.br_en = 1'b1; bus.br_target = t; step(); idle();
    endtask

    task automatic do_call(input logic rel, input logic [7:0] t);
        idle(); bus.call = 1'b1; bus.br_rel = rel; bus.br_target = t; step(); idle();
    endtask

    task automatic do_ret();
        idle(); bus.ret = 1'b1; step(); idle();
    endtask

    task automatic test_reset();
        idle(); rst_n = 1'b0;
        step(); step();
        chk_pc("reset_pc", 8'h00);
        chk_flags("reset_flags", 4'b1000);
        rst_n = 1'b1;
    endtask

    task automatic test_increment();
        logic [7:0] exp;
        exp = 8'h00;
        for (int i = 0; i < 300; i++) begin
            step();
            exp = exp + 8'h01;
            chk_pc("inc", exp);
        end
        chk_flags("inc_flags", 4'b1000);
    endtask

    task automatic test_branch();
        jump_abs(8'h10);
        chk_pc("br_abs_0x10", 8'h10);
        idle(); bus.br_en = 1'b1; bus.br_rel = 1'b1; bus.br_target = 8'hF0; bus.call = 1'b0;
        step();
        chk_pc("br_rel_neg16", 8'h00);
        jump_abs(8'h80);
        chk_pc("br_abs_0x80", 8'h80);
        step();
        chk_pc("br_then_inc", 8'h81);
    endtask

    task automatic test_call_ret();
        jump_abs(8'h20);
        do_call(1'b0, 8'h40);
        chk_pc("call_pc", 8'h40);
        chk_flags("call_flags", 4'b0000);
        do_ret();
        chk_pc("ret_pc", 8'h21);
        chk_flags("ret_flags", 4'b1000);
    endtask

    task automatic test_nested();
        logic [7:0] rets [4];
        rets[0] = 8'h42; rets[1] = 8'h32; rets[2] = 8'h22; rets[3] = 8'h12;
        jump_abs(8'h01);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk_flags("pre5_full", 4'b0100);
            do_call(1'b1, 8'h0F);
            chk_pc("nest_call", 8'(16 * (i + 1)));
            if (i < 4) step();
        end
        chk_flags("nest_ovf", 4'b0110);
        for (int i = 0; i < 4; i++) begin
            do_ret();
            chk_pc("nest_ret", rets[i]);
        end
        chk_flags("nest_drained", 4'b1010);
        do_ret();
        chk_pc("ret_empty_pc", 8'h13);
        chk_flags("ret_empty_unf", 4'b1011);
    endtask

    task automatic test_stall();
        idle(); bus.stall = 1'b1; bus.call = 1'b1; bus.br_target = 8'h70;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pc("stall_pc", 8'h13);
            chk_flags("stall_flags", 4'b1011);
        end
        bus.stall = 1'b0;
        step();
        idle();
        chk_pc("stall_release", 8'h70);
        chk_flags("stall_push", 4'b0011);
        do_ret();
        chk_pc("stall_ret", 8'h14);
        chk_flags("stall_single_push", 4'b1011);
    endtask

    task automatic test_back_to_back();
        jump_abs(8'h2F);
        do_call(1'b0, 8'h4F);
        step();
        chk_pc("xchg_setup", 8'h50);
        idle(); bus.call = 1'b1; bus.ret = 1'b1; bus.br_target = 8'h60;
        step(); idle();
        chk_pc("xchg_pc", 8'h60);
        chk_flags("xchg_count", 4'b0011);
        do_call(1'b0, 8'h70);
        do_ret();
        chk_pc("xchg_inner_ret", 8'h61);
        do_ret();
        chk_pc("xchg_replaced_top", 8'h51);
        chk_flags("xchg_drained", 4'b1011);
        do_call(1'b0, 8'h90);
        idle(); rst_n = 1'b0; bus.call = 1'b1; bus.stall = 1'b1; bus.br_target = 8'hA0;
        step(); idle(); rst_n = 1'b1;
        chk_pc("midrst_pc", 8'h00);
        chk_flags("midrst_flags", 4'b1000);
        do_ret();
        chk_pc("midrst_ret", 8'h01);
        chk_flags("midrst_discarded", 4'b1001);
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_increment();
        test_branch();
        test_call_ret();
        test_nested();
        test_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
